// File: rtl/alu181_nibble_seq.sv
// alu181_nibble_seq: runs a NIBBLES x 4-bit operation through one external
// 74181 slice, least significant nibble first. The carry between passes is
// held in a register instead of being rippled through chained slices.
//
// Optional feature: define ALU181_SEQ_ABORT_EN to add the abort input.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             request, accepted only when idle
//   op_a, op_b        W-bit operands (W = 4*NIBBLES)
//   op_sel, op_mode   74181 function select and mode (1 = logic)
//   op_cin            carry into nibble 0, 74181 pin polarity
//   abort             (optional) cancel a running operation
//   busy, done        status; done is a one-cycle completion pulse
//   result            assembled F, held until the next accepted start
//   carry_out, eq_all final slice carry and AND of every pass's eqAB
//   alu_a .. alu_cin  combinational drive to the slice
//   alu_f, alu_cout, alu_eq  slice outputs
module alu181_nibble_seq #(
   parameter int unsigned NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [4*NIBBLES-1:0] op_a,
   input  logic [4*NIBBLES-1:0] op_b,
   input  logic [3:0]           op_sel,
   input  logic                 op_mode,
   input  logic                 op_cin,
`ifdef ALU181_SEQ_ABORT_EN
   input  logic                 abort,
`endif
   output logic                 busy,
   output logic                 done,
   output logic [4*NIBBLES-1:0] result,
   output logic                 carry_out,
   output logic                 eq_all,
   output logic [3:0]           alu_a,
   output logic [3:0]           alu_b,
   output logic [3:0]           alu_sel,
   output logic                 alu_mode,
   output logic                 alu_cin,
   input  logic [3:0]           alu_f,
   input  logic                 alu_cout,
   input  logic                 alu_eq
);

   localparam int unsigned W    = 4 * NIBBLES;
   localparam int unsigned IDXW = $clog2(NIBBLES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic [W-1:0]      a_l_q, a_l_d;
   logic [W-1:0]      b_l_q, b_l_d;
   logic [3:0]        sel_l_q, sel_l_d;
   logic              mode_l_q, mode_l_d;
   logic              cin_l_q, cin_l_d;
   logic              carry_q, carry_d;
   logic              eq_acc_q, eq_acc_d;
   logic [W-1:0]      result_q, result_d;
   logic              carry_out_q, carry_out_d;
   logic              eq_all_q, eq_all_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         a_l_q       <= '0;
         b_l_q       <= '0;
         sel_l_q     <= '0;
         mode_l_q    <= 1'b0;
         cin_l_q     <= 1'b0;
         carry_q     <= 1'b0;
         eq_acc_q    <= 1'b1;
         result_q    <= '0;
         carry_out_q <= 1'b0;
         eq_all_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         a_l_q       <= a_l_d;
         b_l_q       <= b_l_d;
         sel_l_q     <= sel_l_d;
         mode_l_q    <= mode_l_d;
         cin_l_q     <= cin_l_d;
         carry_q     <= carry_d;
         eq_acc_q    <= eq_acc_d;
         result_q    <= result_d;
         carry_out_q <= carry_out_d;
         eq_all_q    <= eq_all_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      a_l_d       = a_l_q;
      b_l_d       = b_l_q;
      sel_l_d     = sel_l_q;
      mode_l_d    = mode_l_q;
      cin_l_d     = cin_l_q;
      carry_d     = carry_q;
      eq_acc_d    = eq_acc_q;
      result_d    = result_q;
      carry_out_d = carry_out_q;
      eq_all_d    = eq_all_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               a_l_d    = op_a;
               b_l_d    = op_b;
               sel_l_d  = op_sel;
               mode_l_d = op_mode;
               cin_l_d  = op_cin;
               idx_d    = '0;
               eq_acc_d = 1'b1;
               result_d = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            for (int unsigned i = 0; i < NIBBLES; i++) begin
               if (idx_q == IDXW'(i)) begin
                  result_d[4*i +: 4] = alu_f;
               end
            end
            carry_d  = alu_cout;
            eq_acc_d = eq_acc_q & alu_eq;
            if (idx_q == IDXW'(NIBBLES - 1)) begin
               state_d     = DONE;
               carry_out_d = alu_cout;
               eq_all_d    = eq_acc_q & alu_eq;
            end else begin
               idx_d = idx_q + IDXW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
            idx_d   = '0;
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase

`ifdef ALU181_SEQ_ABORT_EN
      // Abort overrides any progression once an operation is under way
      if (abort && (state_q != IDLE)) begin
         state_d     = IDLE;
         idx_d       = '0;
         result_d    = '0;
         carry_out_d = 1'b0;
         eq_all_d    = 1'b0;
      end
`endif

      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   // Slice drive: the nibble selected by idx, carry from the previous pass
   always_comb begin
      alu_a = 4'h0;
      alu_b = 4'h0;
      for (int unsigned i = 0; i < NIBBLES; i++) begin
         if (idx_q == IDXW'(i)) begin
            alu_a = a_l_q[4*i +: 4];
            alu_b = b_l_q[4*i +: 4];
         end
      end
   end

   assign alu_sel   = sel_l_q;
   assign alu_mode  = mode_l_q;
   assign alu_cin   = (idx_q == '0) ? cin_l_q : carry_q;

   assign busy      = busy_q;
   assign done      = done_q;
   assign result    = result_q;
   assign carry_out = carry_out_q;
   assign eq_all    = eq_all_q;

endmodule
